// File: rtl/piezo_pkg.sv
// Shared types and defaults for the piezo alert sequencer.
//   state_t   : sequencer state encoding
//   id_width  : width of an alert index for a given channel count
//   DEF_*     : default timing for a 50 MHz clock
package piezo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BEEP_ON  = 2'd1,
    ST_BEEP_OFF = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  localparam int unsigned DEF_NUM_ALERTS = 3;
  localparam int unsigned DEF_TONE_DIV   = 5000;    // 5 kHz tone at 50 MHz
  localparam int unsigned DEF_TICK_DIV   = 500000;  // 10 ms pattern tick at 50 MHz
  localparam int unsigned DEF_CNT_W      = 8;
  localparam int unsigned BEEP_W         = 4;       // beeps-per-pattern field width

  // Index width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/piezo_prescaler.sv
// Modulo-N counter with synchronous clear and a terminal-count pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable
//   clr        : synchronous clear, wins over en
//   tc_c       : combinational pulse in the last cycle of each N-cycle period
module piezo_prescaler #(
  parameter int unsigned N = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc_c
);

  localparam int unsigned W = (N > 32'd1) ? 32'($clog2(N)) : 32'd1;

  logic [W-1:0] cnt;

  assign tc_c = en && (cnt == W'(N - 32'd1));

  // Count 0..N-1 while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc_c ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/piezo_alert_seq.sv
// Prioritised piezo alert sequencer. Plays a configurable beep pattern for the
// highest-priority (lowest index) requesting alert on a differential tone pair.
//   clk, rst_n          : clock, asynchronous active-low reset
//   alert_req           : level request per alert, index 0 highest priority
//   cfg_beeps/on/off/gap: per-alert pattern config, slice i belongs to alert i
//   audio_o, audio_o_n  : differential piezo drive, both low when silent
//   busy                : high while a pattern is playing
//   active_id           : alert currently being played
// Optional build macro PIEZO_ALERT_PREEMPT_EN: a higher-priority request aborts
// the current pattern at the next tick, inserts one silent tick, then restarts.
module piezo_alert_seq
  import piezo_pkg::*;
#(
  parameter  int unsigned NUM_ALERTS = DEF_NUM_ALERTS,
  parameter  int unsigned TONE_DIV   = DEF_TONE_DIV,
  parameter  int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter  int unsigned CNT_W      = DEF_CNT_W,
  localparam int unsigned IDW        = id_width(NUM_ALERTS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_ALERTS-1:0]        alert_req,
  input  logic [BEEP_W*NUM_ALERTS-1:0] cfg_beeps,
  input  logic [CNT_W*NUM_ALERTS-1:0]  cfg_on,
  input  logic [CNT_W*NUM_ALERTS-1:0]  cfg_off,
  input  logic [CNT_W*NUM_ALERTS-1:0]  cfg_gap,
  output logic                         audio_o,
  output logic                         audio_o_n,
  output logic                         busy,
  output logic [IDW-1:0]               active_id
);

  state_t                state;
  logic [NUM_ALERTS-1:0] req_q;
  logic [BEEP_W-1:0]     sh_beeps;
  logic [CNT_W-1:0]      sh_on;
  logic [CNT_W-1:0]      sh_off;
  logic [CNT_W-1:0]      sh_gap;
  logic [BEEP_W-1:0]     beep_cnt;
  logic [CNT_W-1:0]      tick_cnt;

  logic [IDW-1:0]        win_id;
  logic [BEEP_W-1:0]     win_beeps;
  logic [CNT_W-1:0]      win_on;
  logic [CNT_W-1:0]      win_off;
  logic [CNT_W-1:0]      win_gap;
  logic [BEEP_W-1:0]     eff_beeps;
  logic [CNT_W-1:0]      eff_on;

  logic tick_en, tone_en;
  logic tick_tc_c, tone_tc_c;
  logic req_any, last_beep;
  logic on_last, off_last, gap_last;
  logic pattern_end, start, enter_on, preempt;

  // Lowest-index request wins; select its config slices.
  always_comb begin
    win_id    = '0;
    win_beeps = '0;
    win_on    = '0;
    win_off   = '0;
    win_gap   = '0;
    for (int i = int'(NUM_ALERTS) - 1; i >= 0; i--) begin
      if (req_q[i]) win_id = IDW'(i);
    end
    for (int i = 0; i < int'(NUM_ALERTS); i++) begin
      if (IDW'(i) == win_id) begin
        win_beeps = cfg_beeps[i*BEEP_W +: BEEP_W];
        win_on    = cfg_on[i*CNT_W +: CNT_W];
        win_off   = cfg_off[i*CNT_W +: CNT_W];
        win_gap   = cfg_gap[i*CNT_W +: CNT_W];
      end
    end
  end

  // Zero beep count and zero on-time both behave as one.
  assign eff_beeps = (sh_beeps == '0) ? BEEP_W'(1) : sh_beeps;
  assign eff_on    = (sh_on == '0) ? CNT_W'(1) : sh_on;

  assign req_any   = |req_q;
  assign last_beep = (beep_cnt == eff_beeps - BEEP_W'(1));
  assign on_last   = (state == ST_BEEP_ON)  && tick_tc_c && (tick_cnt == eff_on - CNT_W'(1));
  assign off_last  = (state == ST_BEEP_OFF) && tick_tc_c && (tick_cnt == sh_off - CNT_W'(1));
  assign gap_last  = (state == ST_GAP)      && tick_tc_c && (tick_cnt == sh_gap - CNT_W'(1));

  // A pattern ends at GAP exit, or at the last beep when GAP is skipped.
  assign pattern_end = gap_last || (on_last && last_beep && (sh_gap == '0));
  assign start       = req_any && ((state == ST_IDLE) || pattern_end);
  assign enter_on    = start || off_last || (on_last && !last_beep && (sh_off == '0));

`ifdef PIEZO_ALERT_PREEMPT_EN
  assign preempt = tick_tc_c && req_any && (win_id < active_id) && !pattern_end;
`else
  assign preempt = 1'b0;
`endif

  assign tick_en = (state != ST_IDLE);
  assign tone_en = (state == ST_BEEP_ON);

  piezo_prescaler #(.N(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .clr   (start),
    .tc_c  (tick_tc_c)
  );

  // Cleared on every BEEP_ON entry so each beep starts with the tone high.
  piezo_prescaler #(.N(TONE_DIV)) u_tone (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tone_en),
    .clr   (enter_on),
    .tc_c  (tone_tc_c)
  );

  // Sequencer state, shadow config and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      sh_beeps  <= '0;
      sh_on     <= '0;
      sh_off    <= '0;
      sh_gap    <= '0;
      beep_cnt  <= '0;
      tick_cnt  <= '0;
      active_id <= '0;
      busy      <= 1'b0;
      audio_o   <= 1'b0;
      audio_o_n <= 1'b0;
    end else begin
      req_q <= alert_req;
      if (start) begin
        state     <= ST_BEEP_ON;
        active_id <= win_id;
        sh_beeps  <= win_beeps;
        sh_on     <= win_on;
        sh_off    <= win_off;
        sh_gap    <= win_gap;
        beep_cnt  <= '0;
        tick_cnt  <= '0;
        busy      <= 1'b1;
        audio_o   <= 1'b1;
        audio_o_n <= 1'b0;
      end else if (preempt) begin
        // Reuse GAP as a single silent tick before the new winner starts.
        state     <= ST_GAP;
        sh_gap    <= CNT_W'(1);
        tick_cnt  <= '0;
        audio_o   <= 1'b0;
        audio_o_n <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            busy      <= 1'b0;
            audio_o   <= 1'b0;
            audio_o_n <= 1'b0;
          end
          ST_BEEP_ON: begin
            if (tone_tc_c) begin
              audio_o   <= ~audio_o;
              audio_o_n <= audio_o;
            end
            if (tick_tc_c) begin
              if (on_last) begin
                tick_cnt <= '0;
                if (last_beep) begin
                  audio_o   <= 1'b0;
                  audio_o_n <= 1'b0;
                  if (sh_gap != '0) begin
                    state <= ST_GAP;
                  end else begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                  end
                end else begin
                  beep_cnt <= beep_cnt + BEEP_W'(1);
                  if (sh_off != '0) begin
                    state     <= ST_BEEP_OFF;
                    audio_o   <= 1'b0;
                    audio_o_n <= 1'b0;
                  end else begin
                    audio_o   <= 1'b1;
                    audio_o_n <= 1'b0;
                  end
                end
              end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
              end
            end
          end
          ST_BEEP_OFF: begin
            if (tick_tc_c) begin
              if (off_last) begin
                state     <= ST_BEEP_ON;
                tick_cnt  <= '0;
                audio_o   <= 1'b1;
                audio_o_n <= 1'b0;
              end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
              end
            end
          end
          ST_GAP: begin
            if (tick_tc_c) begin
              if (gap_last) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                tick_cnt <= '0;
              end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piezo_alert_seq.sv
// Self-checking bench for piezo_alert_seq (TONE_DIV=4, TICK_DIV=10, 3 alerts).
// A pattern-level reference model expands each started pattern into a queue of
// expected output samples; tasks compare the DUT against it every cycle.
module tb_piezo_alert_seq;

  localparam int TONE = 4;
  localparam int TICK = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  alert_req;
  logic [11:0] cfg_beeps;
  logic [23:0] cfg_on, cfg_off, cfg_gap;
  logic        audio_o, audio_o_n, busy;
  logic [1:0]  active_id;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  piezo_alert_seq #(
    .NUM_ALERTS (3),
    .TONE_DIV   (TONE),
    .TICK_DIV   (TICK),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alert_req (alert_req),
    .cfg_beeps (cfg_beeps),
    .cfg_on    (cfg_on),
    .cfg_off   (cfg_off),
    .cfg_gap   (cfg_gap),
    .audio_o   (audio_o),
    .audio_o_n (audio_o_n),
    .busy      (busy),
    .active_id (active_id)
  );

  // ---------------- reference model ----------------
  typedef struct packed { logic a; logic an; } samp_t;
  samp_t       exp_q[$];
  samp_t       ms;
  logic        exp_a, exp_an, exp_busy;
  logic [1:0]  exp_id;
  logic [2:0]  req_h1, req_h2;
  logic [11:0] beeps_h1;
  logic [23:0] on_h1, off_h1, gap_h1;
  int          ppos;
  int          mw;

  function automatic int lowest(input logic [2:0] r);
    for (int i = 0; i < 3; i++) if (r[i]) return i;
    return 3;
  endfunction

  // Expand one full pattern for alert w using the config it was started with.
  task automatic build_pattern(input int w);
    int nb, non, noff, ngap;
    samp_t s;
    nb   = int'(beeps_h1[w*4 +: 4]);
    non  = int'(on_h1[w*8 +: 8]);
    noff = int'(off_h1[w*8 +: 8]);
    ngap = int'(gap_h1[w*8 +: 8]);
    if (nb == 0) nb = 1;
    if (non == 0) non = 1;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < non * TICK; k++) begin
        s.a  = ((k / TONE) % 2 == 0);
        s.an = ~s.a;
        exp_q.push_back(s);
      end
      if (b < nb - 1) repeat (noff * TICK) exp_q.push_back(2'b00);
    end
    repeat (ngap * TICK) exp_q.push_back(2'b00);
  endtask

  // Period m: arbitration at the start of m sees requests from period m-2
  // (one input register) and the config present during period m-1.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_a = 0; exp_an = 0; exp_busy = 0; exp_id = 0;
      req_h1 = 0; req_h2 = 0; ppos = 0;
    end else begin
      if (exp_q.size() == 0) begin
        if (|req_h2) begin
          mw = lowest(req_h2);
          exp_id = 2'(mw);
          build_pattern(mw);
          ppos = 0;
        end
      end
`ifdef PIEZO_ALERT_PREEMPT_EN
      else if (ppos > 0 && ppos % TICK == 0 && |req_h2 && lowest(req_h2) < int'(exp_id)) begin
        exp_q.delete();
        repeat (TICK) exp_q.push_back(2'b00);
      end
`endif
      if (exp_q.size() > 0) begin
        ms = exp_q.pop_front();
        exp_a = ms.a; exp_an = ms.an; exp_busy = 1'b1;
        ppos++;
      end else begin
        exp_a = 0; exp_an = 0; exp_busy = 0;
      end
      req_h2 = req_h1;
      req_h1 = alert_req;
      beeps_h1 = cfg_beeps; on_h1 = cfg_on; off_h1 = cfg_off; gap_h1 = cfg_gap;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_req(input logic [2:0] r);
    @(posedge clk); #2;
    alert_req = r;
  endtask

  task automatic set_cfg(input int i, input int b, input int on, input int off, input int gap);
    @(posedge clk); #2;
    cfg_beeps[i*4 +: 4] = 4'(b);
    cfg_on[i*8 +: 8]    = 8'(on);
    cfg_off[i*8 +: 8]   = 8'(off);
    cfg_gap[i*8 +: 8]   = 8'(gap);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; alert_req = '0;
    cfg_beeps = '0; cfg_on = '0; cfg_off = '0; cfg_gap = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({audio_o, audio_o_n, busy, active_id} !== 5'b0)
      $display("FAIL reset_values: got %b%b%b id=%0d want 000 id=0", audio_o, audio_o_n, busy, active_id);
    else passed++;
    @(posedge clk); #2; rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({audio_o, audio_o_n, busy, active_id} !== 5'b0)
        $display("FAIL idle_quiet cyc %0d: got %b%b%b id=%0d want 000 id=0", i, audio_o, audio_o_n, busy, active_id);
      else passed++;
    end
  endtask

  task automatic test_pattern;
    set_cfg(1, 2, 3, 2, 5);
    drive_req(3'b010);
    for (int i = 0; i < 240; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({audio_o, audio_o_n, busy} !== {exp_a, exp_an, exp_busy})
        $display("FAIL pattern cyc %0d: got %b%b%b want %b%b%b", i, audio_o, audio_o_n, busy, exp_a, exp_an, exp_busy);
      else passed++;
      if (exp_busy) begin
        checks++;
        if (active_id !== exp_id) $display("FAIL pattern_id cyc %0d: got %0d want %0d", i, active_id, exp_id);
        else passed++;
      end
      if (i <= 2) begin
        checks++;
        if (audio_o !== (i == 2)) $display("FAIL first_rise cyc %0d: got %b want %b", i, audio_o, (i == 2));
        else passed++;
      end
    end
    drive_req(3'b000);
    for (int i = 0; i < 150; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({audio_o, audio_o_n, busy} !== {exp_a, exp_an, exp_busy})
        $display("FAIL pattern_drain cyc %0d: got %b%b%b want %b%b%b", i, audio_o, audio_o_n, busy, exp_a, exp_an, exp_busy);
      else passed++;
    end
  endtask

  task automatic test_priority;
    set_cfg(0, 1, 2, 0, 1);
    set_cfg(2, 2, 1, 1, 2);
    drive_req(3'b101);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({audio_o, audio_o_n, busy} !== {exp_a, exp_an, exp_busy})
        $display("FAIL priority cyc %0d: got %b%b%b want %b%b%b", i, audio_o, audio_o_n, busy, exp_a, exp_an, exp_busy);
      else passed++;
      if (i >= 2) begin
        checks++;
        if (active_id !== 2'd0) $display("FAIL priority_id cyc %0d: got %0d want 0", i, active_id);
        else passed++;
      end
    end
    drive_req(3'b100);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({audio_o, audio_o_n, busy, active_id} !== {exp_a, exp_an, exp_busy, exp_id})
        $display("FAIL priority_handoff cyc %0d: got %b%b%b id=%0d want %b%b%b id=%0d",
                 i, audio_o, audio_o_n, busy, active_id, exp_a, exp_an, exp_busy, exp_id);
      else passed++;
    end
    drive_req(3'b000);
    repeat (60) @(negedge clk);
  endtask

  task automatic test_preempt;
    set_cfg(2, 3, 4, 1, 2);
    drive_req(3'b100);
    repeat (15) @(negedge clk);
    drive_req(3'b101);
    for (int i = 0; i < 220; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({audio_o, audio_o_n, busy, active_id} !== {exp_a, exp_an, exp_busy, exp_id})
        $display("FAIL preempt cyc %0d: got %b%b%b id=%0d want %b%b%b id=%0d",
                 i, audio_o, audio_o_n, busy, active_id, exp_a, exp_an, exp_busy, exp_id);
      else passed++;
    end
    drive_req(3'b000);
    repeat (200) @(negedge clk);
  endtask

  task automatic test_drop;
    set_cfg(1, 3, 2, 1, 2);
    drive_req(3'b010);
    repeat (8) @(negedge clk);
    drive_req(3'b000);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({audio_o, audio_o_n, busy} !== {exp_a, exp_an, exp_busy})
        $display("FAIL drop cyc %0d: got %b%b%b want %b%b%b", i, audio_o, audio_o_n, busy, exp_a, exp_an, exp_busy);
      else passed++;
    end
    checks++;
    if ({audio_o, audio_o_n, busy} !== 3'b000)
      $display("FAIL drop_idle: got %b%b%b want 000", audio_o, audio_o_n, busy);
    else passed++;
  endtask

  task automatic test_zero_cfg;
    set_cfg(1, 0, 0, 0, 0);
    drive_req(3'b010);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({audio_o, audio_o_n, busy} !== {exp_a, exp_an, exp_busy})
        $display("FAIL zero_cfg cyc %0d: got %b%b%b want %b%b%b", i, audio_o, audio_o_n, busy, exp_a, exp_an, exp_busy);
      else passed++;
    end
    drive_req(3'b000);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_async_reset;
    set_cfg(1, 1, 5, 0, 0);
    drive_req(3'b010);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({audio_o, audio_o_n, busy} !== {exp_a, exp_an, exp_busy})
        $display("FAIL pre_reset cyc %0d: got %b%b%b want %b%b%b", i, audio_o, audio_o_n, busy, exp_a, exp_an, exp_busy);
      else passed++;
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({audio_o, audio_o_n, busy, active_id} !== 5'b0)
      $display("FAIL async_reset: got %b%b%b id=%0d want 000 id=0", audio_o, audio_o_n, busy, active_id);
    else passed++;
    alert_req = '0;
    @(posedge clk); #2; rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({audio_o, audio_o_n, busy} !== {exp_a, exp_an, exp_busy})
        $display("FAIL post_reset cyc %0d: got %b%b%b want %b%b%b", i, audio_o, audio_o_n, busy, exp_a, exp_an, exp_busy);
      else passed++;
    end
  endtask

  task automatic test_random;
    int hold;
    for (int e = 0; e < 25; e++) begin
      for (int a = 0; a < 3; a++)
        set_cfg(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      drive_req(3'($urandom_range(0, 7)));
      hold = $urandom_range(10, 100);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk); #1;
        checks++;
        if ({audio_o, audio_o_n, busy} !== {exp_a, exp_an, exp_busy})
          $display("FAIL random ep %0d cyc %0d: got %b%b%b want %b%b%b", e, i, audio_o, audio_o_n, busy, exp_a, exp_an, exp_busy);
        else passed++;
        if (exp_busy) begin
          checks++;
          if (active_id !== exp_id) $display("FAIL random_id ep %0d cyc %0d: got %0d want %0d", e, i, active_id, exp_id);
          else passed++;
        end
      end
    end
    drive_req(3'b000);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({audio_o, audio_o_n, busy} !== {exp_a, exp_an, exp_busy})
        $display("FAIL random_drain cyc %0d: got %b%b%b want %b%b%b", i, audio_o, audio_o_n, busy, exp_a, exp_an, exp_busy);
      else passed++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pattern();
    test_priority();
    test_preempt();
    test_drop();
    test_zero_cfg();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/piezo_alert_seq.md
Name: piezo_alert_seq

Overview:
Parametrised piezo alert sequencer for the segway controller. It replaces the fixed-period piezo driver.
- Accepts NUM_ALERTS prioritised alert requests (e.g. moving, ovr_spd, batt_low).
- Each alert has a runtime-configurable beep pattern: beep count, on/off/gap durations.
- Drives a differential square-wave tone pair to the piezo.
- Sits between the balance/monitor logic and the piezo pins.

Parameters:
- NUM_ALERTS, 3, number of request channels; index 0 is highest priority.
- TONE_DIV, 5000, clk cycles per tone half-period (5 kHz at 50 MHz).
- TICK_DIV, 500000, clk cycles per pattern tick (10 ms at 50 MHz).
- CNT_W, 8, width of per-alert on/off/gap tick counts.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- alert_req  in  NUM_ALERTS  level request per alert
- cfg_beeps  in  4*NUM_ALERTS  beeps per pattern; slice i belongs to alert i
- cfg_on  in  CNT_W*NUM_ALERTS  beep-on ticks per alert
- cfg_off  in  CNT_W*NUM_ALERTS  inter-beep silent ticks per alert
- cfg_gap  in  CNT_W*NUM_ALERTS  end-of-pattern silent ticks per alert
- audio_o  out  1  piezo drive, positive
- audio_o_n  out  1  piezo drive, negative
- busy  out  1  high while state is not IDLE
- active_id  out  IDW  alert being played; IDW = max(1, clog2(NUM_ALERTS))

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. All state updates on posedge clk.
- Reset values: audio_o=0, audio_o_n=0, busy=0, active_id=0, state IDLE, all counters 0.
- States: IDLE, BEEP_ON, BEEP_OFF, GAP.
- Arbitration: lowest-index asserted alert_req wins. Arbitration happens only in IDLE and at GAP exit.
- Pattern start (IDLE with any request, or GAP exit with any request):
  - latch the winner's id and its cfg slices into shadow registers;
  - clear the tick prescaler, tone divider and beep counter;
  - enter BEEP_ON the next cycle.
- Cfg changes mid-pattern have no effect until the next pattern start.
- Durations are exact: each state lasts N*TICK_DIV cycles, where N is its latched count.
- Zero handling: beeps=0 is treated as 1; on=0 is treated as 1; off=0 skips BEEP_OFF; gap=0 skips GAP.
- BEEP_ON end:
  - if this was the last beep, go to GAP;
  - otherwise go to BEEP_OFF, then back to BEEP_ON.
- GAP end: if any request is asserted, start a new pattern (new winner); otherwise go to IDLE.
- Request deasserted mid-pattern: the pattern still completes through GAP. This guarantees a minimum audible alert.
- Tone generation:
  - on BEEP_ON entry, tone=1;
  - tone toggles every TONE_DIV cycles while in BEEP_ON.
- Outputs are registered:
  - in BEEP_ON, audio_o=tone and audio_o_n=~tone;
  - in every other state, both outputs are 0 (no DC across the piezo).
- Timing: audio_o rises in the first cycle that state==BEEP_ON, i.e. 2 cycles after alert_req rises in IDLE.
- Prescalers run only while busy; they are frozen at 0 in IDLE.

Optional Feature:
- Macro: PIEZO_ALERT_PREEMPT_EN.
- Defined: a request with a lower index than active_id aborts the current pattern at the next tick pulse.
  - Outputs go silent for exactly one tick, then a new pattern starts for the new winner.
- Undefined: no preemption; the current pattern always completes through GAP.

Decomposition:
- Shared package piezo_pkg holds:
  - state enum typedef;
  - IDW computation function;
  - default localparams for 50 MHz timing.
- One sub-module, piezo_prescaler: parametrised modulo-N counter with sync clear and a terminal-count pulse. Instantiated twice, once for the tone and once for the tick.

Test Plan:
Bench parameters: TONE_DIV=4, TICK_DIV=10, NUM_ALERTS=3.
1. Reset, then hold reset -> audio_o=0, audio_o_n=0, busy=0, active_id=0; outputs stay 0 with no request.
2. alert_req=3'b010 with beeps=2, on=3, off=2, gap=5 -> 30 cycles toggling every 4 cycles (starting high, 2 cycles after req), 20 silent, 30 toggling, 50 silent, then repeat.
3. alert_req=3'b101 at once -> active_id=0; alert 0's cfg governs timing; alert 2 is played only once alert 0 drops and its pattern completes.
4. Alert 2 playing, alert 0 asserted mid-BEEP_ON:
   - without macro, alert 0 starts after alert 2's GAP;
   - with macro, silence at the next tick, then alert 0 BEEP_ON 10 cycles later.
5. Request dropped during first BEEP_ON -> remaining beeps and GAP complete, then IDLE; busy falls and outputs stay 0.
6. Zero cfg (beeps=0, on=0, off=0, gap=0) -> single 10-cycle beep repeated back-to-back while the request is held. Separately: rst_n asserted mid-beep -> outputs 0 asynchronously.
